// File: rtl/traceback_sched.sv
// Scheduler between the ACS/max-metric pipeline and the traceback unit: decision-memory write
// sequencing, fill tracking, traceback request handshake with one pending slot, normalization.
module traceback_sched #(
    parameter int unsigned             size        = 8,
    parameter int unsigned             ADDR_W      = 5,
    parameter int unsigned             TB_LEN      = 24,
    parameter logic signed [size+3:0]  NORM_THRESH = 12'sh400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              symEn,
    input  logic              maxValid,
    input  logic [4:0]        maxIndex,
    input  logic [size+3:0]   maxVal,
    output logic              decWrEn,
    output logic [ADDR_W-1:0] decWrAddr,
    output logic              tbReq,
    input  logic              tbAck,
    output logic [4:0]        tbStartState,
    output logic [ADDR_W-1:0] tbStartAddr,
    output logic              normEn,
    output logic              primed,
    output logic              overflow
);

    localparam int unsigned       FillW   = $clog2(TB_LEN + 1);
    localparam logic [FillW-1:0]  FillMax = FillW'(TB_LEN);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    state_e              state_q, state_d;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q, wr_ptr_q, last_addr_q;
    logic [FillW-1:0]    fill_q;
    logic                norm_arm_q;
    logic [4:0]          act_st_q, act_st_d, pend_st_q, pend_st_d;
    logic [ADDR_W-1:0]   act_ad_q, act_ad_d, pend_ad_q, pend_ad_d;
    logic                pend_v_q, pend_v_d;
    logic                ovf_q, ovf_d;
    logic                qual;
    logic                arm;

    // Qualification samples the fill state before any write completing this cycle.
    assign qual = maxValid && (fill_q == FillMax);
    assign arm  = qual && ($signed(maxVal) >= NORM_THRESH);

    assign decWrEn      = wr_en_q;
    assign decWrAddr    = wr_addr_q;
    assign tbReq        = (state_q == StReq);
    assign tbStartState = act_st_q;
    assign tbStartAddr  = act_ad_q;
    assign normEn       = norm_arm_q && wr_en_q;
    assign primed       = (fill_q == FillMax) || (wr_en_q && (fill_q == FillMax - 1'b1));
    assign overflow     = ovf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_ptr_q    <= '0;
            last_addr_q <= '0;
            fill_q      <= '0;
            norm_arm_q  <= 1'b0;
        end else begin
            wr_en_q <= symEn;
            if (symEn) begin
                wr_addr_q <= wr_ptr_q;
                wr_ptr_q  <= wr_ptr_q + 1'b1;
            end
            if (wr_en_q) begin
                last_addr_q <= wr_addr_q;
                if (fill_q != FillMax) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
            // A fire consumes the arm; a re-arm in that same cycle is absorbed.
            if (normEn) begin
                norm_arm_q <= 1'b0;
            end else if (arm) begin
                norm_arm_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        act_st_d  = act_st_q;
        act_ad_d  = act_ad_q;
        pend_v_d  = pend_v_q;
        pend_st_d = pend_st_q;
        pend_ad_d = pend_ad_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (qual) begin
                    act_st_d = maxIndex;
                    act_ad_d = last_addr_q;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (qual) begin
                    pend_st_d = maxIndex;
                    pend_ad_d = last_addr_q;
                    pend_v_d  = 1'b1;
                    if (pend_v_q) begin
                        ovf_d = 1'b1;
                    end
                end
                if (tbAck) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (pend_v_q) begin
                    act_st_d = pend_st_q;
                    act_ad_d = pend_ad_q;
                    state_d  = StReq;
                    if (qual) begin
                        pend_st_d = maxIndex;
                        pend_ad_d = last_addr_q;
                    end else begin
                        pend_v_d = 1'b0;
                    end
                end else if (qual) begin
                    act_st_d = maxIndex;
                    act_ad_d = last_addr_q;
                    state_d  = StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            act_st_q  <= '0;
            act_ad_q  <= '0;
            pend_v_q  <= 1'b0;
            pend_st_q <= '0;
            pend_ad_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_st_q  <= act_st_d;
            act_ad_q  <= act_ad_d;
            pend_v_q  <= pend_v_d;
            pend_st_q <= pend_st_d;
            pend_ad_q <= pend_ad_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_traceback_sched.sv
// Directed plus randomized bench for traceback_sched, checked every cycle against a
// transaction-level model (request queue of depth two, fill count, arm flag).
module tb_traceback_sched;

    localparam int TB_LEN = 24;
    localparam int DEPTH  = 32;
    localparam int THRESH = 1024;

    logic        clk = 1'b0;
    logic        reset, symEn, maxValid, tbAck;
    logic [4:0]  maxIndex;
    logic [11:0] maxVal;
    logic        decWrEn, tbReq, normEn, primed, overflow;
    logic [4:0]  decWrAddr, tbStartAddr, tbStartState;

    traceback_sched dut (
        .clk          (clk),
        .reset        (reset),
        .symEn        (symEn),
        .maxValid     (maxValid),
        .maxIndex     (maxIndex),
        .maxVal       (maxVal),
        .decWrEn      (decWrEn),
        .decWrAddr    (decWrAddr),
        .tbReq        (tbReq),
        .tbAck        (tbAck),
        .tbStartState (tbStartState),
        .tbStartAddr  (tbStartAddr),
        .normEn       (normEn),
        .primed       (primed),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {int st; int ad;} req_t;

    int   n_checks = 0;
    int   n_err    = 0;
    // Model: q[0] is the request being presented, q[1] the pending one.
    req_t q[$];
    int   mode;     // 0 idle, 1 requesting, 2 one-cycle gap after ack
    int   mfill, mptr, mlast, mwaddr;
    bit   mwr, movf, marm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = 0; mfill = 0; mptr = 0; mlast = 0; mwaddr = 0;
        mwr = 0; movf = 0; marm = 0;
    endtask

    task automatic model_step(input bit rn, input bit s, input bit mv, input int idx,
                              input int val, input bit ack);
        bit   qual;
        int   sval;
        req_t cand;
        if (!rn) begin
            model_reset();
            return;
        end
        qual = mv && (mfill >= TB_LEN);
        sval = (val >= 2048) ? val - 4096 : val;
        cand.st = idx;
        cand.ad = mlast;
        if (marm && mwr) marm = 0;
        else if (qual && sval >= THRESH) marm = 1;
        case (mode)
            0: if (qual) begin q.push_back(cand); mode = 1; end
            1: begin
                if (qual) begin
                    if (q.size() == 2) begin q[1] = cand; movf = 1; end
                    else q.push_back(cand);
                end
                if (ack) begin void'(q.pop_front()); mode = 2; end
            end
            default: begin
                if (qual) q.push_back(cand);
                mode = (q.size() > 0) ? 1 : 0;
            end
        endcase
        if (mwr) begin
            mlast = mwaddr;
            if (mfill < TB_LEN) mfill++;
        end
        mwr = s;
        if (s) begin
            mwaddr = mptr;
            mptr = (mptr + 1) % DEPTH;
        end
    endtask

    task automatic check_outputs();
        chk("decWrEn", 32'(decWrEn), 32'(mwr));
        if (mwr) chk("decWrAddr", 32'(decWrAddr), 32'(mwaddr));
        chk("primed", 32'(primed), 32'((mfill + int'(mwr)) >= TB_LEN));
        chk("tbReq", 32'(tbReq), 32'(mode == 1));
        if (mode == 1) begin
            chk("tbStartState", 32'(tbStartState), 32'(q[0].st));
            chk("tbStartAddr", 32'(tbStartAddr), 32'(q[0].ad));
        end
        chk("normEn", 32'(normEn), 32'(marm && mwr));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic cyc(input bit rn, input bit s, input bit mv, input int idx, input int val,
                       input bit ack);
        reset = rn; symEn = s; maxValid = mv; tbAck = ack;
        maxIndex = 5'(idx); maxVal = 12'(val);
        check_outputs();
        model_step(rn, s, mv, idx, val, ack);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, ack);
    endtask

    initial begin
        reset = 0; symEn = 0; maxValid = 0; tbAck = 0; maxIndex = 0; maxVal = 0;
        @(posedge clk);
        #1;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_tbStartState", 32'(tbStartState), 0);
        chk("rst_tbStartAddr", 32'(tbStartAddr), 0);
        chk("rst_decWrAddr", 32'(decWrAddr), 0);

        // Fill: maxValid lands on every decWrEn cycle, including the one that raises primed.
        for (int i = 0; i < TB_LEN; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            cyc(1, 0, 1, i % 20, 12'h500, 0);
            idle(4, 0);
        end
        chk("fill_no_req", 32'(tbReq), 0);
        chk("fill_no_norm_arm", 32'(normEn), 0);
        chk("fill_primed", 32'(primed), 1);

        // Handshake: index 13 held for ten cycles without ack.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 13, 5, 0);
        idle(10, 0);
        chk("hs_state", 32'(tbStartState), 13);
        cyc(1, 0, 0, 0, 0, 1);
        chk("hs_drop", 32'(tbReq), 0);
        idle(3, 0);

        // Pending and overflow: 2 presented, then 5 and 9 contend for the pending slot.
        cyc(1, 0, 1, 2, 5, 0);
        idle(2, 0);
        cyc(1, 0, 1, 5, 5, 0);
        idle(2, 0);
        cyc(1, 0, 1, 9, 5, 0);
        chk("ovf_set", 32'(overflow), 1);
        idle(3, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("ovf_next_state", 32'(tbStartState), 9);
        cyc(1, 0, 0, 0, 0, 1);
        idle(3, 0);

        // Normalization at, below and far below (negative) the threshold.
        cyc(1, 0, 1, 4, 12'h400, 1);
        idle(2, 1);
        cyc(1, 1, 0, 0, 0, 1);
        chk("norm_fire", 32'(normEn), 1);
        idle(2, 1);
        cyc(1, 0, 1, 4, 12'h3FF, 1);
        cyc(1, 1, 0, 0, 0, 1);
        chk("norm_below", 32'(normEn), 0);
        cyc(1, 0, 1, 4, 12'h800, 1);
        cyc(1, 1, 0, 0, 0, 1);
        idle(3, 1);

        // Wrap: enough symbols to pass the end of the address space, requests riding along.
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 0, 0, 1);
            cyc(1, 0, 1, i % 20, 100, 1);
            cyc(1, 0, 0, 0, 0, 1);
        end
        idle(3, 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int val;
            val = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095))
                                              : int'($urandom_range(12'h3F0, 12'h410));
            cyc(1, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                int'($urandom_range(0, 19)), val, $urandom_range(0, 2) == 0);
        end
        idle(4, 1);

        // Reset while a request and a pending one are outstanding.
        cyc(1, 0, 1, 3, 5, 0);
        cyc(1, 0, 1, 7, 5, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("mid_req_high", 32'(tbReq), 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("mid_rst_state", 32'(tbStartState), 0);
        chk("mid_rst_addr", 32'(tbStartAddr), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            cyc(1, 0, 1, 11, 12'h500, 0);
        end
        idle(4, 0);
        chk("post_rst_no_req", 32'(tbReq), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
